// File: rtl/trig_lut_if.sv
// Requester, response and LUT-side signals of the shared sin/cos LUT scheduler.
// The master modport is the requester/LUT side; the slave modport is the scheduler.
interface trig_lut_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_op;
    logic [N_REQ*DATA_W-1:0] req_angle;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_value;
    logic                    lut_op;
    logic [DATA_W-1:0]       lut_angle;
    logic [DATA_W-1:0]       lut_value;
    logic                    busy;

    modport master (
        output req_valid, req_op, req_angle, lut_value,
        input  req_ready, rsp_valid, rsp_value, lut_op, lut_angle, busy
    );

    modport slave (
        input  req_valid, req_op, req_angle, lut_value,
        output req_ready, rsp_valid, rsp_value, lut_op, lut_angle, busy
    );
endinterface

// File: rtl/trig_lut_scheduler.sv
// Round-robin share of one sin/cos LUT; grant->response LUT_LAT+1 cycles (1 on a cache hit),
// no response backpressure, requesters wait on req_ready. LUT_CACHE_EN adds a one-entry result cache.
module trig_lut_scheduler #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int LUT_LAT = 1
) (
    input logic       clk,
    input logic       rst,
    trig_lut_if.slave bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, id_q, grant_idx, next_ptr, scan_idx;
    logic [CW-1:0]     cnt_q;
    logic              grant_found, grant_take, lookup_done, cache_hit;
    logic              lut_op_q, sel_op;
    logic [DATA_W-1:0] lut_angle_q, rsp_value_q, sel_angle, cache_value;
    logic [N_REQ-1:0]  req_ready_c, rsp_valid_c;

    // First pending requester at or above rr_ptr, wrapping past N_REQ-1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = IDW'((int'(rr_ptr_q) + k) % N_REQ);
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign sel_op    = bus.req_op[grant_idx];
    assign sel_angle = bus.req_angle[grant_idx*DATA_W +: DATA_W];
    assign next_ptr  = (grant_idx == IDW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;

`ifdef LUT_CACHE_EN
    logic              cache_vld_q, cache_op_q;
    logic [DATA_W-1:0] cache_angle_q, cache_value_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_vld_q   <= 1'b0;
            cache_op_q    <= 1'b0;
            cache_angle_q <= '0;
            cache_value_q <= '0;
        end else if (lookup_done) begin
            cache_vld_q   <= 1'b1;
            cache_op_q    <= lut_op_q;
            cache_angle_q <= lut_angle_q;
            cache_value_q <= bus.lut_value;
        end
    end

    assign cache_hit   = cache_vld_q && (cache_op_q == sel_op) && (cache_angle_q == sel_angle);
    assign cache_value = cache_value_q;
`else
    assign cache_hit   = 1'b0;
    assign cache_value = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Grant is combinational so the requester sees ready in the same cycle it is chosen.
    always_comb begin
        state_d     = state_q;
        req_ready_c = '0;
        rsp_valid_c = '0;
        grant_take  = 1'b0;
        lookup_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found && !rst) begin
                    req_ready_c = N_REQ'(1) << grant_idx;
                    grant_take  = 1'b1;
                    state_d     = cache_hit ? DONE : LOOKUP;
                end
            end
            LOOKUP: begin
                if (cnt_q == '0) begin
                    lookup_done = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                rsp_valid_c = N_REQ'(1) << id_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            lut_op_q    <= 1'b0;
            lut_angle_q <= '0;
            rsp_value_q <= '0;
        end else begin
            if (grant_take) begin
                lut_op_q    <= sel_op;
                lut_angle_q <= sel_angle;
                id_q        <= grant_idx;
                rr_ptr_q    <= next_ptr;
                cnt_q       <= CW'(LUT_LAT-1);
                if (cache_hit) rsp_value_q <= cache_value;
            end
            if (state_q == LOOKUP && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            if (lookup_done) rsp_value_q <= bus.lut_value;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_value = rsp_value_q;
    assign bus.lut_op    = lut_op_q;
    assign bus.lut_angle = lut_angle_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_trig_lut_scheduler.sv
// Bench for trig_lut_scheduler: LUT_LAT=1 instance scoreboarded, LUT_LAT=4 instance hand-checked.
module tb_trig_lut_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    trig_lut_if #(.N_REQ(4), .DATA_W(32)) bus_a ();
    trig_lut_if #(.N_REQ(4), .DATA_W(32)) bus_b ();

    trig_lut_scheduler #(.N_REQ(4), .DATA_W(32), .LUT_LAT(1)) u_dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    trig_lut_scheduler #(.N_REQ(4), .DATA_W(32), .LUT_LAT(4)) u_dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    function automatic logic [31:0] lut_fn(input logic op, input logic [31:0] a);
        return op ? ((a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A) : ({a[15:0], a[31:16]} + 32'h1234_0007);
    endfunction

    assign bus_a.lut_value = lut_fn(bus_a.lut_op, bus_a.lut_angle);
    assign bus_b.lut_value = lut_fn(bus_b.lut_op, bus_b.lut_angle);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard for instance A ----------------
    typedef struct {
        logic [3:0]  onehot;
        logic [31:0] value;
        int          due;
    } exp_t;
    exp_t sb[$];

    int          m_ptr = 0;
    logic [3:0]  m_g, m_r, m_exp;
    int          m_w;
    bit          m_f, m_hit, c_vld;
    logic        m_op, c_op;
    logic [31:0] m_ang, c_ang;
    exp_t        m_e;

    always @(negedge clk) begin
        #2;
        if (rst_a) begin
            sb.delete();
            m_ptr = 0;
            c_vld = 1'b0;
        end else begin
            m_g = bus_a.req_ready;
            if (m_g != 4'b0) begin
                chk("grant_while_busy", 64'(sb.size()), 64'd0);
                m_f = 1'b0;
                m_w = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!m_f && bus_a.req_valid[(m_ptr + k) % 4]) begin
                        m_f = 1'b1;
                        m_w = (m_ptr + k) % 4;
                    end
                end
                m_exp = m_f ? (4'b0001 << m_w) : 4'b0000;
                chk("grant_rr", m_g, m_exp);
                m_op  = bus_a.req_op[m_w];
                m_ang = bus_a.req_angle[m_w*32 +: 32];
                m_hit = 1'b0;
`ifdef LUT_CACHE_EN
                m_hit = c_vld && (c_op == m_op) && (c_ang == m_ang);
                if (!m_hit) begin
                    c_vld = 1'b1;
                    c_op  = m_op;
                    c_ang = m_ang;
                end
`endif
                m_e.onehot = m_exp;
                m_e.value  = lut_fn(m_op, m_ang);
                m_e.due    = cyc + (m_hit ? 1 : 2);
                sb.push_back(m_e);
                m_ptr = (m_w + 1) % 4;
            end
            m_r = bus_a.rsp_valid;
            if (m_r != 4'b0) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", m_r, 4'b0);
                end else begin
                    m_e = sb.pop_front();
                    chk("rsp_id", m_r, m_e.onehot);
                    chk("rsp_value", bus_a.rsp_value, m_e.value);
                    chk("rsp_cycle", 64'(cyc), 64'(m_e.due));
                end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
                m_e = sb.pop_front();
                chk("rsp_missing", m_r, m_e.onehot);
            end
        end
    end

    // Call at a falling edge; returns at falling edge + 1 of the grant cycle.
    task automatic wait_grant(input bit sel, output logic [3:0] g, output int t);
        bit found = 1'b0;
        g = '0;
        t = cyc;
        for (int n = 0; n < 20 && !found; n++) begin
            #1;
            g = sel ? bus_b.req_ready : bus_a.req_ready;
            t = cyc;
            if (g != 4'b0) found = 1'b1;
            else           @(negedge clk);
        end
        if (!found) chk("grant_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  op;
        logic [31:0] base;
        logic [3:0]  exp_grant;
    } vec_t;
    vec_t vecs[8];

    logic [3:0]  g, prev_g;
    int          t, t1, t2;
    int          gt[3];
    logic [3:0]  exp2[3];
    int          cnt[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pointer history after the earlier hand tests leaves rr_ptr = 1 at table start.
        vecs[0] = '{4'b1111, 4'b1010, 32'h0000_0100, 4'b0010};
        vecs[1] = '{4'b1111, 4'b0101, 32'h0000_0200, 4'b0100};
        vecs[2] = '{4'b0011, 4'b0011, 32'h0000_0300, 4'b0001};
        vecs[3] = '{4'b1000, 4'b1000, 32'h0000_0400, 4'b1000};
        vecs[4] = '{4'b1010, 4'b0010, 32'h0000_0500, 4'b0010};
        vecs[5] = '{4'b0001, 4'b0000, 32'h0000_0600, 4'b0001};
        vecs[6] = '{4'b0001, 4'b0001, 32'h0000_0700, 4'b0001};
        vecs[7] = '{4'b0100, 4'b1111, 32'h0000_0800, 4'b0100};
        exp2[0] = 4'b0010; exp2[1] = 4'b0100; exp2[2] = 4'b0010;

        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.req_valid = '0; bus_a.req_op = '0; bus_a.req_angle = '0;
        bus_b.req_valid = '0; bus_b.req_op = '0; bus_b.req_angle = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready",  bus_a.req_ready, 4'b0);
        chk("rst_rsp",    bus_a.rsp_valid, 4'b0);
        chk("rst_value",  bus_a.rsp_value, 32'h0);
        chk("rst_lut_op", bus_a.lut_op, 1'b0);
        chk("rst_angle",  bus_a.lut_angle, 32'h0);
        chk("rst_busy",   bus_a.busy, 1'b0);

        // Two requesters held from reset: alternate, LUT_LAT+2 cycles apart.
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        bus_a.req_valid = 4'b0110;
        bus_a.req_op    = 4'b0110;
        bus_a.req_angle = {32'h2000_0300, 32'h2000_0200, 32'h2000_0100, 32'h2000_0000};
        for (int k = 0; k < 3; k++) begin
            wait_grant(1'b0, g, t);
            gt[k] = t;
            chk("t2_grant", g, exp2[k]);
            @(negedge clk);
        end
        bus_a.req_valid = '0;
        drain();
        chk("t2_spacing0", 64'(gt[1] - gt[0]), 64'd3);
        chk("t2_spacing1", 64'(gt[2] - gt[1]), 64'd3);

        // Single request: grant now, response two cycles later, busy in between.
        @(negedge clk);
        bus_a.req_valid = 4'b0001;
        bus_a.req_op    = 4'b0001;
        bus_a.req_angle = {32'h0, 32'h0, 32'h0, 32'h3F};
        wait_grant(1'b0, g, t);
        chk("t1_grant", g, 4'b0001);
        @(negedge clk);
        bus_a.req_valid = '0;
        #1;
        chk("t1_busy1", bus_a.busy, 1'b1);
        chk("t1_norsp", bus_a.rsp_valid, 4'b0);
        @(negedge clk); #1;
        chk("t1_busy2", bus_a.busy, 1'b1);
        chk("t1_rsp",   bus_a.rsp_valid, 4'b0001);
        chk("t1_value", bus_a.rsp_value, lut_fn(1'b1, 32'h3F));
        @(negedge clk); #1;
        chk("t1_idle",  bus_a.busy, 1'b0);
        drain();

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus_a.req_valid = vecs[i].valid;
            bus_a.req_op    = vecs[i].op;
            bus_a.req_angle = {vecs[i].base + 32'h3000, vecs[i].base + 32'h2000,
                               vecs[i].base + 32'h1000, vecs[i].base};
            wait_grant(1'b0, g, t);
            chk("vec_grant", g, vecs[i].exp_grant);
            @(negedge clk);
            bus_a.req_valid = '0;
            drain();
        end

        // All four active for 16 grants, starting from rr_ptr = 3.
        @(negedge clk);
        bus_a.req_valid = 4'b1111;
        bus_a.req_op    = 4'b1001;
        bus_a.req_angle = {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
        for (int r = 0; r < 4; r++) cnt[r] = 0;
        prev_g = '0;
        for (int k = 0; k < 16; k++) begin
            wait_grant(1'b0, g, t);
            chk("t3_order", g, 4'b0001 << ((3 + k) % 4));
            chk("t3_norepeat", 64'(g == prev_g), 64'd0);
            for (int r = 0; r < 4; r++) if (g[r]) cnt[r]++;
            prev_g = g;
            @(negedge clk);
        end
        bus_a.req_valid = '0;
        drain();
        for (int r = 0; r < 4; r++) chk("t3_count", 64'(cnt[r]), 64'd4);

        // Back-to-back identical requests; second one hits the cache when it exists.
        @(negedge clk);
        bus_a.req_valid = 4'b0001;
        bus_a.req_op    = 4'b0000;
        bus_a.req_angle = {32'h0, 32'h0, 32'h0, 32'h10};
        wait_grant(1'b0, g, t1);
        chk("t5_grant1", g, 4'b0001);
        @(negedge clk);
        wait_grant(1'b0, g, t2);
        chk("t5_grant2", g, 4'b0001);
        chk("t5_spacing", 64'(t2 - t1), 64'd3);
        @(negedge clk);
        bus_a.req_valid = '0;
        #1;
`ifdef LUT_CACHE_EN
        chk("t5_hit_rsp", bus_a.rsp_valid, 4'b0001);
        chk("t5_hit_val", bus_a.rsp_value, lut_fn(1'b0, 32'h10));
`else
        chk("t5_miss_rsp", bus_a.rsp_valid, 4'b0000);
`endif
        drain();

        // LUT_LAT=4: inputs held four cycles, response five cycles after grant.
        @(negedge clk);
        bus_b.req_valid = 4'b0100;
        bus_b.req_op    = 4'b0100;
        bus_b.req_angle = {32'h33, 32'hABCD_0000, 32'h11, 32'h00};
        wait_grant(1'b1, g, t);
        chk("t6_grant", g, 4'b0100);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus_b.req_valid = '0;
                bus_b.req_angle = '1;
            end
            #1;
            chk("t6_angle_hold", bus_b.lut_angle, 32'hABCD_0000);
            chk("t6_norsp", bus_b.rsp_valid, 4'b0);
        end
        @(negedge clk); #1;
        chk("t6_rsp",   bus_b.rsp_valid, 4'b0100);
        chk("t6_value", bus_b.rsp_value, lut_fn(1'b1, 32'hABCD_0000));

        // Reset during LOOKUP aborts the transaction and rewinds rr_ptr.
        @(negedge clk);
        bus_b.req_valid = 4'b0010;
        bus_b.req_op    = 4'b0010;
        bus_b.req_angle = {32'h0, 32'h0, 32'h5555_0001, 32'h0};
        wait_grant(1'b1, g, t);
        chk("t4_grant", g, 4'b0010);
        @(negedge clk);
        bus_b.req_valid = '0;
        @(negedge clk);
        rst_b = 1'b1;
        bus_b.req_valid = 4'b1111;
        #1;
        chk("t4_rst_ready", bus_b.req_ready, 4'b0);
        chk("t4_rst_rsp",   bus_b.rsp_valid, 4'b0);
        chk("t4_rst_value", bus_b.rsp_value, 32'h0);
        chk("t4_rst_op",    bus_b.lut_op, 1'b0);
        chk("t4_rst_angle", bus_b.lut_angle, 32'h0);
        chk("t4_rst_busy",  bus_b.busy, 1'b0);
        @(negedge clk);
        rst_b = 1'b0;
        bus_b.req_valid = '0;
        #1;
        chk("t4_post_rsp0", bus_b.rsp_valid, 4'b0);
        @(negedge clk); #1;
        chk("t4_post_rsp1", bus_b.rsp_valid, 4'b0);
        chk("t4_post_busy", bus_b.busy, 1'b0);
        @(negedge clk);
        bus_b.req_valid = 4'b1111;
        bus_b.req_op    = 4'b0001;
        bus_b.req_angle = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};
        wait_grant(1'b1, g, t);
        chk("t4_regrant", g, 4'b0001);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) bus_b.req_valid = '0;
            #1;
            chk("t4_norsp", bus_b.rsp_valid, 4'b0);
        end
        @(negedge clk); #1;
        chk("t4_rsp",   bus_b.rsp_valid, 4'b0001);
        chk("t4_value", bus_b.rsp_value, lut_fn(1'b1, 32'h7777_0000));

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
